abc_vector_gen: RTL
===================

ABC_VECTOR_GEN -- requirements
Module: abc_vector_gen

Interface
REQ-001 Parameter: HOLD_CYCLES, default 10, cycles each vector is held on a/b/c; legal range 1..255.
REQ-002 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
REQ-005 Port: mode  input  2  sweep order, sampled on accepted start: 00 binary, 01 Gray, 10 fixed table, 11 treated as binary.
REQ-006 Port: a  output  1  stimulus bit a to the downstream 3-input circuit.
REQ-007 Port: b  output  1  stimulus bit b.
REQ-008 Port: c  output  1  stimulus bit c.
REQ-009 Port: vld  output  1  high for exactly the first cycle a new vector is presented.
REQ-010 Port: vec_idx  output  3  step number (0..7) of the vector currently driven.
REQ-011 Port: busy  output  1  high while a sweep is in progress.
REQ-012 Port: done  output  1  one-cycle pulse after the last vector's hold completes.

Function
REQ-013 FSM SHALL have states IDLE, RUN, FIN; reset state IDLE.
REQ-014 IDLE: a=b=c=0, vld=0, busy=0, done=0, vec_idx=0.
REQ-015 IDLE + start=1 at edge N SHALL latch mode, enter RUN; at edge N+1 outputs show step 0 vector, vld=1, busy=1.
REQ-016 Each step SHALL be held exactly HOLD_CYCLES cycles; the next step's vector and vld appear on the cycle after the hold ends (no gap cycles).
REQ-017 Vector {a,b,c} for step i: binary = i; Gray = i ^ (i>>1); table = 000,111,010,101,001,110,100,011 for i=0..7.
REQ-018 After step 7 hold ends, FSM SHALL enter FIN for one cycle: done=1, busy=0, a/b/c=0, vld=0; then IDLE.
REQ-019 start asserted in RUN or FIN SHALL be ignored (no restart, no queueing).
REQ-020 start asserted in the same cycle FIN is left SHALL not be accepted; start is accepted only when the state is IDLE at that edge.
REQ-021 mode changes during RUN SHALL not affect the current sweep.
REQ-022 HOLD_CYCLES=1 SHALL give a new vector and vld=1 every cycle; sweep spans 8 cycles plus FIN.
REQ-023 Hold counter SHALL count 0..HOLD_CYCLES-1 and wrap to 0 at each step boundary; width 8 bits.
REQ-024 Step counter SHALL be 3 bits; its wrap from 7 SHALL coincide with the RUN->FIN transition, never restart a step.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE and all outputs to REQ-014 values on the next cycle, including mid-RUN and during FIN.
REQ-026 rst overrides start in the same cycle; no sweep begins.
REQ-027 Latched mode, hold counter and step counter SHALL clear to 0 on reset.

Structure
REQ-028 Package abc_vec_pkg SHALL hold the state enum, mode constants (MODE_BIN, MODE_GRAY, MODE_TBL) and the 8-entry fixed vector table.
REQ-029 Hold-timing logic SHALL be a sub-module abc_hold_ctr (inputs: clk, rst, load; output: expire), instantiated once.
REQ-030 Outputs a, b, c, vld, busy, done SHALL be registered; no combinational path from start or mode to any output.

Verification
REQ-031 HOLD_CYCLES=10, mode=00, start pulse -> a/b/c step through 000..111, each held 10 cycles, vld 8 pulses 10 cycles apart, done 80 cycles after first vld.
REQ-032 mode=01 -> vector sequence 000,001,011,010,110,111,101,100.
REQ-033 mode=10 -> sequence 000,111,010,101,001,110,100,011; vec_idx 0..7 in step.
REQ-034 rst=1 during step 3 -> next cycle a=b=c=0, busy=0, done stays 0; later start restarts from step 0.
REQ-035 start re-pulsed during RUN and mode flipped to 10 while running with mode=00 -> sweep unchanged, single done pulse.
REQ-036 HOLD_CYCLES=1 -> vld high 8 consecutive cycles, vectors change every cycle, done on 9th cycle after start edge.

Source files
------------

// File: rtl/abc_vec_pkg.sv
// Shared types and constants for the a/b/c stimulus vector generator.
package abc_vec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_BIN  = 2'b00;
    localparam logic [1:0] MODE_GRAY = 2'b01;
    localparam logic [1:0] MODE_TBL  = 2'b10;

    // Fixed sweep order, entry i sits at bits [3*i +: 3]: 000,111,010,101,001,110,100,011
    localparam logic [7:0][2:0] VEC_TABLE = {
        3'b011, 3'b100, 3'b110, 3'b001, 3'b101, 3'b010, 3'b111, 3'b000
    };

    // Vector {a,b,c} driven for a given step; mode 11 falls back to binary order
    function automatic logic [2:0] vec_for(input logic [1:0] m, input logic [2:0] i);
        case (m)
            MODE_GRAY: return i ^ (i >> 1);
            MODE_TBL:  return VEC_TABLE[i];
            default:   return i;
        endcase
    endfunction

endpackage

// File: rtl/abc_vector_gen_if.sv
// Control and stimulus bundle between a requester and the vector generator.
interface abc_vector_gen_if;

    logic       start;
    logic [1:0] mode;
    logic       a;
    logic       b;
    logic       c;
    logic       vld;
    logic [2:0] vec_idx;
    logic       busy;
    logic       done;

    modport master (
        output start, mode,
        input  a, b, c, vld, vec_idx, busy, done
    );

    modport slave (
        input  start, mode,
        output a, b, c, vld, vec_idx, busy, done
    );

endinterface

// File: rtl/abc_hold_ctr.sv
// Per-step hold timer: counts 0..HOLD_CYCLES-1 and flags the last cycle of a step.
module abc_hold_ctr #(
    parameter int unsigned HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

    logic [7:0] count;

    // Restart on load so the first step is aligned to the accepted start, then wrap every step
    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/abc_vector_gen.sv
// Sweeps all eight {a,b,c} combinations in a selectable order, holding each vector
// for HOLD_CYCLES cycles, then pulses done for one cycle.
module abc_vector_gen
    import abc_vec_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 10
) (
    input logic              clk,
    input logic              rst,
    abc_vector_gen_if.slave  bus
);

    state_t     state;
    state_t     next_state;
    logic [2:0] step;
    logic [2:0] next_step;
    logic [1:0] mode_q;
    logic [1:0] next_mode;
    logic       load;
    logic       expire;

    logic [2:0] abc_q;
    logic [2:0] next_abc;
    logic [2:0] idx_q;
    logic [2:0] next_idx;
    logic       vld_q;
    logic       next_vld;
    logic       busy_q;
    logic       next_busy;
    logic       done_q;
    logic       next_done;

    abc_hold_ctr #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .expire (expire)
    );

    // Control state: FSM state, current step and the mode captured at start
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            step   <= '0;
            mode_q <= '0;
        end else begin
            state  <= next_state;
            step   <= next_step;
            mode_q <= next_mode;
        end
    end

    // Next state plus the values the output registers take at the coming edge
    always_comb begin
        next_state = state;
        next_step  = step;
        next_mode  = mode_q;
        next_vld   = 1'b0;
        load       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = RUN;
                    next_step  = '0;
                    next_mode  = bus.mode;
                    next_vld   = 1'b1;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (expire) begin
                    next_step = step + 3'd1;
                    if (step == 3'd7) begin
                        next_state = FIN;
                    end else begin
                        next_vld = 1'b1;
                    end
                end
            end
            FIN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        next_busy = (next_state == RUN);
        next_done = (next_state == FIN);
        next_abc  = (next_state == RUN) ? vec_for(next_mode, next_step) : 3'b000;
        next_idx  = (next_state == RUN) ? next_step : 3'd0;
    end

    // Registered outputs so nothing from start or mode reaches a pin combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            abc_q  <= '0;
            idx_q  <= '0;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            abc_q  <= next_abc;
            idx_q  <= next_idx;
            vld_q  <= next_vld;
            busy_q <= next_busy;
            done_q <= next_done;
        end
    end

    assign bus.a       = abc_q[2];
    assign bus.b       = abc_q[1];
    assign bus.c       = abc_q[0];
    assign bus.vec_idx = idx_q;
    assign bus.vld     = vld_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
